// File: rtl/lcd_pkg.sv
// Shared types, command codes and helpers for the HD44780 character LCD controller.
// Optional power-up init sequence is enabled with the LCD_INIT_EN macro.
package lcd_pkg;

  // The init-ROM step takes no cycle of its own. The next ROM byte is
  // captured on the edge that leaves power-up or the previous byte's wait,
  // and the FSM goes straight to S_SETUP.
  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

  localparam int LCD_INIT_LEN = 6;

  // Clear and home (including the 8'h03 alias of home) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME || data == 8'h03);
  endfunction

`ifdef LCD_INIT_EN
  // Init sequence: function set three times, display on, clear, entry mode.
  function automatic logic [7:0] init_rom_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0, 3'd1, 3'd2: b = LCD_CMD_FUNCSET;
      3'd3:             b = LCD_CMD_DISPON;
      3'd4:             b = LCD_CMD_CLEAR;
      default:          b = LCD_CMD_ENTRY;
    endcase
    return b;
  endfunction
`endif

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that times every phase of the LCD controller.
// done is high while the count is 1, which is the last cycle of a phase.
module lcd_timer #(
  parameter int          W       = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Reload on a state change; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= W'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-compatible character LCD controller, physical pin side.
// Accepts command/data bytes through a valid/ready handshake.
// Each byte is driven with setup, enable-pulse, hold and execution-wait timing.
// Define LCD_INIT_EN to play the built-in init ROM after the power-up wait.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC = 750000,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned PULSE_CYC = 25,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned EXEC_CYC  = 2000,
  parameter int unsigned LONG_CYC  = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_vld,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_rdy,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  localparam int unsigned MAX_CYC = (PWRUP_CYC > LONG_CYC) ? PWRUP_CYC : LONG_CYC;
  localparam int          TW      = $clog2(MAX_CYC + 1);

  lcd_state_e    state, next_state;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          cap_en;
  logic          cap_rs;
  logic [7:0]    cap_data;
  logic          lcd_rs_q;
  logic [7:0]    lcd_data_q;
  logic          lcd_en_q;
  logic          lcd_on_q;
  logic          init_done_q;
`ifdef LCD_INIT_EN
  logic [2:0]    rom_idx;
  logic          init_busy;
  logic          rom_step;
  logic          init_clr;
`endif

  lcd_timer #(
    .W       (TW),
    .RST_VAL (PWRUP_CYC)
  ) u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next state, timer reload and byte capture for each phase of a transfer.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    cap_en     = 1'b0;
    cap_rs     = 1'b0;
    cap_data   = 8'h00;
`ifdef LCD_INIT_EN
    rom_step   = 1'b0;
    init_clr   = 1'b0;
`endif
    case (state)
      S_PWRUP: begin
        if (tmr_done) begin
`ifdef LCD_INIT_EN
          next_state = S_SETUP;
          tmr_load   = 1'b1;
          tmr_val    = TW'(SETUP_CYC);
          cap_en     = 1'b1;
          cap_data   = init_rom_byte(3'd0);
          rom_step   = 1'b1;
`else
          next_state = S_IDLE;
`endif
        end
      end
      S_IDLE: begin
        if (i_vld) begin
          next_state = S_SETUP;
          tmr_load   = 1'b1;
          tmr_val    = TW'(SETUP_CYC);
          cap_en     = 1'b1;
          cap_rs     = i_rs;
          cap_data   = i_data;
        end
      end
      S_SETUP: begin
        if (tmr_done) begin
          next_state = S_PULSE;
          tmr_load   = 1'b1;
          tmr_val    = TW'(PULSE_CYC);
        end
      end
      S_PULSE: begin
        if (tmr_done) begin
          next_state = S_HOLD;
          tmr_load   = 1'b1;
          tmr_val    = TW'(HOLD_CYC);
        end
      end
      S_HOLD: begin
        if (tmr_done) begin
          next_state = S_WAIT;
          tmr_load   = 1'b1;
          tmr_val    = is_long_cmd(lcd_rs_q, lcd_data_q) ? TW'(LONG_CYC) : TW'(EXEC_CYC);
        end
      end
      S_WAIT: begin
        if (tmr_done) begin
`ifdef LCD_INIT_EN
          if (init_busy && rom_idx != 3'(LCD_INIT_LEN)) begin
            next_state = S_SETUP;
            tmr_load   = 1'b1;
            tmr_val    = TW'(SETUP_CYC);
            cap_en     = 1'b1;
            cap_data   = init_rom_byte(rom_idx);
            rom_step   = 1'b1;
          end else begin
            next_state = S_IDLE;
            init_clr   = init_busy;
          end
`else
          next_state = S_IDLE;
`endif
        end
      end
      default: next_state = S_PWRUP;
    endcase
  end

  // State register; reset restarts the power-up wait from the beginning.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_PWRUP;
    end else begin
      state <= next_state;
    end
  end

  // Registered pin drivers; RS/DATA keep the last byte between transfers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      lcd_en_q    <= 1'b0;
      lcd_on_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      lcd_on_q    <= 1'b1;
      lcd_en_q    <= (next_state == S_PULSE);
      init_done_q <= init_done_q | (next_state == S_IDLE);
      if (cap_en) begin
        lcd_rs_q   <= cap_rs;
        lcd_data_q <= cap_data;
      end
    end
  end

`ifdef LCD_INIT_EN
  // Walks the init ROM and remembers that the init sequence is still running.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rom_idx   <= 3'd0;
      init_busy <= 1'b0;
    end else if (rom_step) begin
      rom_idx   <= rom_idx + 3'd1;
      init_busy <= 1'b1;
    end else if (init_clr) begin
      init_busy <= 1'b0;
    end
  end
`endif

  assign o_rdy       = (state == S_IDLE);
  assign o_init_done = init_done_q;
  assign o_lcd_on    = lcd_on_q;
  assign o_lcd_en    = lcd_en_q;
  assign o_lcd_rs    = lcd_rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with shortened timing parameters.
// A transaction-level model predicts every output on every cycle.
// Directed checks pin latencies and pulse widths to hand-computed numbers.
module tb_lcd_ctrl;

  localparam int PW = 20;
  localparam int S  = 2;
  localparam int P  = 4;
  localparam int H  = 2;
  localparam int E  = 10;
  localparam int L  = 40;
`ifdef LCD_INIT_EN
  localparam int INIT_CYC = 158;
`else
  localparam int INIT_CYC = 20;
`endif

  logic       clk;
  logic       rst_n;
  logic       vld;
  logic       rs_in;
  logic [7:0] data_in;
  logic       o_rdy;
  logic       o_init_done;
  logic       o_lcd_on;
  logic       o_lcd_en;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic [7:0] o_lcd_data;

  int tests = 0;
  int fails = 0;

  // Model state: cycles since release, power-up countdown, current byte and its phase.
  int         cyc = 0;
  int         m_pwr = PW;
  bit         m_active = 0;
  int         m_pos = 0;
  int         m_dur = 0;
  bit         m_rdy = 0;
  bit         m_done = 0;
  bit         m_on = 0;
  logic       m_rs = 0;
  logic [7:0] m_data = 0;
  bit         m_en;
  int         acc_cyc_q[$];
  logic [8:0] acc_byte_q[$];
`ifdef LCD_INIT_EN
  int         m_rom = 0;
  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
`endif

  // Observed enable pulses on the DUT pins.
  logic       prev_en = 0;
  int         hi_cnt = 0;
  int         last_width = 0;
  logic [7:0] pulse_data[$];
  logic       pulse_rs[$];

  lcd_ctrl #(
    .PWRUP_CYC (PW),
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .HOLD_CYC  (H),
    .EXEC_CYC  (E),
    .LONG_CYC  (L)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_vld       (vld),
    .i_rs        (rs_in),
    .i_data      (data_in),
    .o_rdy       (o_rdy),
    .o_init_done (o_init_done),
    .o_lcd_on    (o_lcd_on),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_data  (o_lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Starts a byte: total time is setup + pulse + hold + execution wait.
  task automatic modelStart(input logic r, input logic [7:0] d);
    m_active = 1;
    m_pos    = 0;
    m_rs     = r;
    m_data   = d;
    m_rdy    = 0;
    m_dur    = S + P + H + ((r == 1'b0 && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? L : E);
  endtask

  // Advance the model on each edge, then compare every output 1 time unit later.
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0; m_pwr = PW; m_active = 0; m_pos = 0; m_rdy = 0; m_done = 0;
      m_on = 0; m_rs = 0; m_data = 0;
`ifdef LCD_INIT_EN
      m_rom = 0;
`endif
    end else begin
      cyc++;
      m_on = 1;
      if (m_pwr > 0) begin
        m_pwr--;
        if (m_pwr == 0) begin
`ifdef LCD_INIT_EN
          modelStart(1'b0, rom[0]);
          m_rom = 1;
`else
          m_rdy  = 1;
          m_done = 1;
`endif
        end
      end else if (m_active) begin
        m_pos++;
        if (m_pos == m_dur) begin
          m_active = 0;
`ifdef LCD_INIT_EN
          if (m_rom < 6) begin
            modelStart(1'b0, rom[m_rom]);
            m_rom++;
          end else begin
            m_rdy  = 1;
            m_done = 1;
          end
`else
          m_rdy  = 1;
          m_done = 1;
`endif
        end
      end else if (m_rdy && vld) begin
        modelStart(rs_in, data_in);
        acc_cyc_q.push_back(cyc);
        acc_byte_q.push_back({rs_in, data_in});
      end
    end
    #1;
    m_en = m_active && m_pos >= S && m_pos < S + P;
    checkOutput("rdy",       o_rdy,       m_rdy);
    checkOutput("init_done", o_init_done, m_done);
    checkOutput("lcd_on",    o_lcd_on,    m_on);
    checkOutput("lcd_en",    o_lcd_en,    m_en);
    checkOutput("lcd_rs",    o_lcd_rs,    m_rs);
    checkOutput("lcd_rw",    o_lcd_rw,    1'b0);
    checkOutput("lcd_data",  o_lcd_data,  m_data);
    if (!rst_n) begin
      prev_en = 0;
      hi_cnt  = 0;
    end else begin
      if (o_lcd_en) begin
        if (!prev_en) begin
          pulse_data.push_back(o_lcd_data);
          pulse_rs.push_back(o_lcd_rs);
        end
        hi_cnt++;
      end else if (prev_en) begin
        last_width = hi_cnt;
        hi_cnt     = 0;
      end
      prev_en = o_lcd_en;
    end
  end

  task automatic applyStimulus(input logic v, input logic r, input logic [7:0] d);
    @(negedge clk);
    vld     = v;
    rs_in   = r;
    data_in = d;
  endtask

  task automatic waitReady();
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #2;
      if (o_rdy) return;
    end
    checkOutput("rdy_timeout", o_rdy, 1'b1);
  endtask

  task automatic waitInitDone();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      if (o_init_done) begin
        checkOutput("init_done_cycle", cyc, INIT_CYC);
        return;
      end
    end
    checkOutput("init_done_timeout", o_init_done, 1'b1);
  endtask

  task automatic checkInitPulses();
`ifdef LCD_INIT_EN
    logic [7:0] exp_b;
    checkOutput("init_pulse_count", pulse_data.size(), 6);
    for (int i = 0; i < pulse_data.size() && i < 6; i++) begin
      exp_b = rom[i];
      checkOutput($sformatf("init_pulse%0d_data", i), pulse_data[i], exp_b);
      checkOutput($sformatf("init_pulse%0d_rs", i), pulse_rs[i], 1'b0);
    end
`else
    checkOutput("pwrup_pulse_count", pulse_data.size(), 0);
`endif
  endtask

  // One handshake: accept, check captured pins, then ready latency and pulse shape.
  task automatic sendByte(input logic r, input logic [7:0] d, input int expLat, input string name);
    int lat;
    waitReady();
    applyStimulus(1'b1, r, d);
    applyStimulus(1'b0, r, d);
    checkOutput({name, "_rs"}, o_lcd_rs, r);
    checkOutput({name, "_data"}, o_lcd_data, d);
    waitReady();
    lat = (acc_cyc_q.size() > 0) ? cyc - acc_cyc_q[$] : -1;
    checkOutput({name, "_latency"}, lat, expLat);
    checkOutput({name, "_en_width"}, last_width, 4);
    checkOutput({name, "_en_data"}, (pulse_data.size() > 0) ? pulse_data[$] : 8'hxx, d);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n0;
    rst_n = 1'b0; vld = 1'b0; rs_in = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk);
    #2;
    checkOutput("lcd_on_first_cycle", o_lcd_on, 1'b1);
    checkOutput("rdy_during_pwrup", o_rdy, 1'b0);
    waitInitDone();
    checkOutput("rdy_at_init_done", o_rdy, 1'b1);
    checkInitPulses();

    sendByte(1'b1, 8'h41, 18, "data_41");
    sendByte(1'b0, 8'h01, 48, "cmd_clear");
    sendByte(1'b0, 8'h0C, 18, "cmd_dispon");
    sendByte(1'b0, 8'h02, 48, "cmd_home");
    sendByte(1'b0, 8'h03, 48, "cmd_03");
    sendByte(1'b1, 8'h01, 18, "data_01");

    // vld held high across two bytes: ready returns 18 cycles after the
    // first accept and the second byte is taken on the following edge.
    waitReady();
    n0 = acc_cyc_q.size();
    applyStimulus(1'b1, 1'b1, 8'h55);
    applyStimulus(1'b1, 1'b1, 8'hAA);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (acc_cyc_q.size() >= n0 + 2) break;
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    waitReady();
    checkOutput("held_accept_count", acc_cyc_q.size(), n0 + 2);
    if (acc_cyc_q.size() >= n0 + 2) begin
      checkOutput("held_first_byte", acc_byte_q[n0], 9'h155);
      checkOutput("held_second_byte", acc_byte_q[n0+1], 9'h1AA);
      checkOutput("held_spacing", acc_cyc_q[n0+1] - acc_cyc_q[n0], 19);
    end

    // Randomised traffic, including vld pulses while busy.
    for (int i = 0; i < 1500; i++) begin
      logic       v;
      logic       r;
      logic [7:0] d;
      v = ($urandom_range(0, 9) < 3);
      r = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      applyStimulus(v, r, d);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    waitReady();

    // Reset while EN is high: outputs clear at once, power-up repeats.
    applyStimulus(1'b1, 1'b0, 8'h0C);
    applyStimulus(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (o_lcd_en) break;
    end
    checkOutput("en_before_reset", o_lcd_en, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_en",   o_lcd_en,    1'b0);
    checkOutput("async_rst_rdy",  o_rdy,       1'b0);
    checkOutput("async_rst_done", o_init_done, 1'b0);
    checkOutput("async_rst_on",   o_lcd_on,    1'b0);
    checkOutput("async_rst_rs",   o_lcd_rs,    1'b0);
    checkOutput("async_rst_data", o_lcd_data,  8'h00);
    repeat (2) @(negedge clk);
    pulse_data.delete();
    pulse_rs.delete();
    rst_n = 1'b1;
    waitInitDone();
    checkInitPulses();
    sendByte(1'b1, 8'h7A, 18, "post_reset_data");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
